// File: rtl/obi_arbiter_2to1.sv
// Round-robin 2:1 arbiter for the req/gnt/rvalid RAM protocol, in-order owner-ID FIFO for response routing.
// Optional perf counters are built when OBI_ARB_PERF_EN is defined; otherwise the perf ports read 0.
module obi_arbiter_2to1 #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      m0_req_i,
  input  logic                      m1_req_i,
  output logic                      m0_gnt_o,
  output logic                      m1_gnt_o,
  output logic                      m0_rvalid_o,
  output logic                      m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
  input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
  input  logic                      m0_we_i,
  input  logic                      m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,
  output logic                      s_req_o,
  input  logic                      s_gnt_i,
  input  logic                      s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]     s_addr_o,
  output logic                      s_we_o,
  output logic [DATA_WIDTH/8-1:0]   s_be_o,
  output logic [DATA_WIDTH-1:0]     s_wdata_o,
  input  logic [DATA_WIDTH-1:0]     s_rdata_i,
  output logic                      proto_err_o,
  output logic [31:0]               perf_grants_o,
  output logic [31:0]               perf_conflicts_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                       lock_q, lock_d;
  logic                       lock_id_q, lock_id_d;
  logic                       last_grant_q, last_grant_d;
  logic                       proto_err_q, proto_err_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;

  logic sel_c, sel_req_c, full_c, empty_c, hs_c, pop_c, head_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      proto_err_q  <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_q       <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      proto_err_q  <= proto_err_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_q       <= fifo_d;
    end
  end

  // Selection, forwarding and response routing (zero latency, forced idle in reset)
  always_comb begin
    sel_c = 1'b0;
    if (lock_q) begin
      sel_c = lock_id_q;
    end else if (m0_req_i && m1_req_i) begin
      sel_c = ~last_grant_q;
    end else if (m1_req_i) begin
      sel_c = 1'b1;
    end
    sel_req_c   = sel_c ? m1_req_i : m0_req_i;
    full_c      = (count_q == CNT_W'(MAX_OUTSTANDING));
    empty_c     = (count_q == '0);
    s_req_o     = rst_ni & sel_req_c & ~full_c;
    hs_c        = s_req_o & s_gnt_i;
    m0_gnt_o    = hs_c & ~sel_c;
    m1_gnt_o    = hs_c & sel_c;
    s_addr_o    = sel_c ? m1_addr_i  : m0_addr_i;
    s_we_o      = sel_c ? m1_we_i    : m0_we_i;
    s_be_o      = sel_c ? m1_be_i    : m0_be_i;
    s_wdata_o   = sel_c ? m1_wdata_i : m0_wdata_i;
    pop_c       = rst_ni & s_rvalid_i & ~empty_c;
    head_c      = fifo_q[rd_ptr_q];
    m0_rvalid_o = pop_c & ~head_c;
    m1_rvalid_o = pop_c & head_c;
    m0_rdata_o  = s_rdata_i;
    m1_rdata_o  = s_rdata_i;
    proto_err_o = proto_err_q;
  end

  // Next state: lock, round-robin pointer, owner FIFO, sticky error
  always_comb begin
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    proto_err_d  = proto_err_q | (s_rvalid_i & empty_c);
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_d       = fifo_q;
    if (hs_c) begin
      lock_d           = 1'b0;
      last_grant_d     = sel_c;
      fifo_d[wr_ptr_q] = sel_c;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (sel_req_c) begin
      lock_d    = 1'b1;
      lock_id_d = sel_c;
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (hs_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!hs_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

`ifdef OBI_ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;

  always_comb begin
    perf_grants_d    = perf_grants_q + 32'(hs_c);
    perf_conflicts_d = perf_conflicts_q + 32'(m0_req_i & m1_req_i & ~lock_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_grants_q    <= '0;
      perf_conflicts_q <= '0;
    end else begin
      perf_grants_q    <= perf_grants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_grants_o    = perf_grants_q;
  assign perf_conflicts_o = perf_conflicts_q;
`else
  assign perf_grants_o    = 32'd0;
  assign perf_conflicts_o = 32'd0;
`endif

endmodule

// File: doc/obi_arbiter_2to1.md
Name: obi_arbiter_2to1

Overview:
Two-master to one-slave arbiter for the req/gnt/rvalid memory protocol used between zeroriscy_core and sp_ram. It sits directly upstream of a single shared sp_ram instance. Master 0 is the core instruction port and master 1 is the core data port, so one RAM serves both code and data. It arbitrates round-robin, keeps a lost request stable until granted, and routes each rvalid back to its owner through an in-order ID FIFO.

Parameters:
MAX_OUTSTANDING, 2, depth of the owner-ID FIFO; maximum granted-but-unanswered transactions (1..4).
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m0_req_i, m1_req_i  in  1  master request
m0_gnt_o, m1_gnt_o  out  1  master grant
m0_rvalid_o, m1_rvalid_o  out  1  response valid to the owning master
m0_addr_i, m1_addr_i  in  ADDR_WIDTH  address
m0_we_i, m1_we_i  in  1  write enable
m0_be_i, m1_be_i  in  DATA_WIDTH/8  byte enables
m0_wdata_i, m1_wdata_i  in  DATA_WIDTH  write data
m0_rdata_o, m1_rdata_o  out  DATA_WIDTH  read data (s_rdata_i broadcast to both)
s_req_o  out  1  slave request
s_gnt_i  in  1  slave grant
s_rvalid_i  in  1  slave response valid
s_addr_o  out  ADDR_WIDTH  muxed address
s_we_o  out  1  muxed write enable
s_be_o  out  DATA_WIDTH/8  muxed byte enables
s_wdata_o  out  DATA_WIDTH  muxed write data
s_rdata_i  in  DATA_WIDTH  slave read data
proto_err_o  out  1  sticky protocol-error flag
perf_grants_o  out  32  grant counter (optional feature)
perf_conflicts_o  out  32  conflict counter (optional feature)

Behaviour:
- Reset state: ID FIFO empty (count=0), last_grant=1, lock=0, proto_err_o=0, perf counters=0.
- Combinational outputs during reset: all gnt/rvalid/s_req_o are 0.
- Selection when lock=0:
  - Only one master requests: select that master.
  - Both request: select the master that is not last_grant. After reset, master 0 wins the first conflict.
- Selection when lock=1: hold the locked master (lock_id).
- Forwarding:
  - s_req_o = selected master's req AND (count < MAX_OUTSTANDING).
  - s_addr/we/be/wdata are muxed from the selected master.
  - mX_gnt_o = s_req_o AND s_gnt_i AND (sel==X).
  - All of these are zero added latency (combinational).
- Lock:
  - Set lock=1 and lock_id=sel when s_req_o=1 but s_gnt_i=0, or when the selected req is blocked because the FIFO is full.
  - Clear lock on the granting cycle.
  - A pending request never has its address or data switched to the other master.
- Handshake (s_req_o & s_gnt_i):
  - Push sel into the ID FIFO.
  - Update last_grant=sel.
  - Masters must hold req and payload stable until gnt (protocol rule, not checked).
- Response:
  - On s_rvalid_i, pop the FIFO head and assert m<head>_rvalid_o in the same cycle.
  - The other master's rvalid stays 0.
  - Responses are strictly in order. With sp_ram, rvalid arrives 1 cycle after gnt, so the turnaround is fully pipelined.
- Simultaneous push and pop in one cycle: the count is unchanged and the head advances.
- Full condition: s_req_o is blocked when count==MAX_OUTSTANDING, even if s_rvalid_i pops in the same cycle. This keeps rvalid out of the req path.
- s_rvalid_i with an empty FIFO:
  - Response is dropped; no master rvalid is asserted.
  - proto_err_o is set and stays 1 until reset.
- FIFO pointers wrap modulo MAX_OUTSTANDING. count has width $clog2(MAX_OUTSTANDING+1).
- Reset mid-operation: the FIFO is flushed. Any rvalid that arrives afterwards for a pre-reset grant sets proto_err_o.

Optional Feature:
OBI_ARB_PERF_EN.
- Defined:
  - perf_grants_o increments on every slave handshake.
  - perf_conflicts_o increments on every cycle where both reqs are high and lock=0.
  - Both are 32-bit, wrap at 2^32, and have registered outputs.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Only m0_req=1 at addr 0x0, sp_ram model (gnt same cycle, rvalid +1) -> m0_gnt=1 in cycle 0; m0_rvalid=1 with data in cycle 1; m1_rvalid never asserted.
- Both masters request continuously for 4 cycles (m0 addr 0x10, m1 addr 0x20) -> grants m0,m1,m0,m1; each rvalid returns to the correct master 1 cycle later; with OBI_ARB_PERF_EN, perf_conflicts_o=4 and perf_grants_o=4.
- m1 requests, slave holds gnt=0 for 3 cycles, m0 raises req in cycle 1 -> s_addr stays 0x20 (m1) until granted in cycle 3; m0 is granted in cycle 4.
- MAX_OUTSTANDING=2, slave grants every cycle but delays rvalid 3 cycles -> the third request is blocked (s_req_o=0) until the first rvalid; rvalid owners match the grant order.
- s_rvalid_i pulsed with no outstanding grant -> no master rvalid; proto_err_o=1 and stays 1; the next rst_ni low clears it to 0.
- rst_ni asserted while 1 transaction is outstanding -> all outputs 0 during reset; a late rvalid after release sets proto_err_o and is not routed to any master.
